grf_write_arbiter: RTL and testbench
====================================

GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: number of side-queue entries, power of two.
REQ-002 Parameter AGE_MAX, default 8: cycles an un-granted queue head waits before a stall is requested.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-005 w_valid  input  1  pipeline W-stage write request.
REQ-006 w_addr  input  5  pipeline destination register.
REQ-007 w_data  input  32  pipeline write data.
REQ-008 w_pc  input  32  pipeline instruction PC.
REQ-009 q_valid  input  1  side requester (multi-cycle unit) offers a write.
REQ-010 q_ready  output  1  side queue can accept; equals (count < DEPTH), registered-state based.
REQ-011 q_addr / q_data / q_pc  input  5/32/32  side write payload.
REQ-012 rs / rt  input  5/5  decode-stage source registers for hazard lookup.
REQ-013 hit_rs / hit_rt  output  1/1  a stored queue entry targets rs / rt.
REQ-014 reg_addr / reg_data / reg_pc  output  5/32/32  register-file write port; reg_addr==0 means no write.
REQ-015 stall_req  output  1  registered request to freeze the pipeline's W stage.

Function
REQ-016 Pipeline priority: if w_valid==1, the port SHALL carry w_addr/w_data/w_pc combinationally in the same cycle.
REQ-017 If w_valid==0 and the queue is non-empty, the port SHALL carry the head entry, and the head SHALL pop at that edge.
REQ-018 If neither source is active, reg_addr/reg_data/reg_pc SHALL be 0.
REQ-019 A push occurs when q_valid && q_ready at an edge; an entry is grantable no earlier than the following cycle.
REQ-020 A push with q_addr==0 SHALL be handshaken and discarded; the queue is not modified.
REQ-021 Simultaneous push and pop SHALL both occur; the count is unchanged.
REQ-022 When full, q_ready==0; a pop in that cycle does not raise q_ready until the next cycle.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; the count range is 0..DEPTH.
REQ-024 Queue order SHALL be strict FIFO; entries with duplicate addresses SHALL retire in push order.
REQ-025 hit_rs SHALL be 1 iff rs!=0 and some valid stored entry has addr==rs; the same rule applies to hit_rt. Both are combinational from stored state, and the entry being pushed in the current cycle is excluded.
REQ-026 Head age counter: reset to 0 on pop or when the queue is empty; otherwise +1 per cycle, saturating at AGE_MAX.
REQ-027 stall_req SHALL be set at the edge where the age reaches AGE_MAX and cleared at the edge where the head pops.
REQ-028 While stall_req==1, upstream guarantees w_valid==0. If w_valid is nevertheless 1, the pipeline still wins and no write is lost.

Reset
REQ-029 On reset==0, count, pointers and age SHALL be 0, stall_req SHALL be 0, and the next-cycle q_ready SHALL be 1.
REQ-030 Reset mid-operation SHALL discard all queued entries; payload storage need not be cleared.
REQ-031 During a reset cycle, the outputs SHALL follow REQ-016/018 with the queue treated as empty.

Structure
REQ-032 A shared package SHALL hold the REG_ZERO constant (5'd0) and the write-entry struct {addr[4:0], data[31:0], pc[31:0]}.
REQ-033 A single sub-module wb_fifo (DEPTH-entry storage with pointers, count and per-entry address compare) SHALL be used; arbitration and aging live in the top level.

Verification
REQ-034 Pipeline only: w_valid=1, w_addr=5, w_data=0x1234 -> reg_addr=5, reg_data=0x1234 in the same cycle; queue untouched.
REQ-035 Push q_addr=3/q_data=0xAA while w_valid=0 -> next cycle reg_addr=3, reg_data=0xAA, and hit_rs (rs=3) drops after the pop.
REQ-036 Push 4 entries (addrs 1,2,3,4) with w_valid=1 held -> q_ready=0; releasing w_valid drains them in order 1,2,3,4 on consecutive cycles.
REQ-037 Hold w_valid=1 with one queued entry -> stall_req rises after 8 cycles; dropping w_valid grants the entry and clears stall_req at the next edge.
REQ-038 q_addr=0 push -> q_ready stays 1, count stays 0, and no write appears on the port.
REQ-039 Queue 3 entries, then reset=0 for one cycle -> count=0, hit_rs=hit_rt=0, stall_req=0, and no queued write ever appears.

Source files
------------

// File: rtl/grf_write_arbiter_pkg.sv
// Shared types for the GRF write arbiter: the write-entry record and the
// "no write" register address.
package grf_write_arbiter_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_entry_t;

    // Register 0 is never a real destination, so it can never alias a hazard.
    function automatic logic addr_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/grf_write_arbiter_wb_fifo.sv
// Side-write queue: DEPTH-entry FIFO with count, wrapping pointers and a
// per-entry destination compare for decode-stage hazard lookup.
module wb_fifo
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  wr_entry_t push_entry_i,
    input  logic      pop_i,
    output wr_entry_t head_o,
    output logic      empty_o,
    output logic      full_o,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic      hit_rs_o,
    output logic      hit_rt_o
);

    // DEPTH is a power of two, so plain pointer overflow gives the wrap.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wr_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;
    logic [DEPTH-1:0] m_rs, m_rt;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload needs no reset; the valid bits decide what is live.
    always_ff @(posedge clk_i) begin
        if (do_push && rst_ni) mem_q[wr_ptr_q] <= push_entry_i;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign m_rs[i] = vld_q[i] && addr_hit(rs_i, mem_q[i].addr);
        assign m_rt[i] = vld_q[i] && addr_hit(rt_i, mem_q[i].addr);
    end

    assign hit_rs_o = |m_rs;
    assign hit_rt_o = |m_rt;

endmodule

// File: rtl/grf_write_arbiter.sv
// Register-file write port arbiter: the pipeline W stage always wins, queued
// side writes fill idle cycles, and a starved queue head requests a stall.
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AGE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_valid,
    input  logic [4:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic [31:0] w_pc,
    input  logic        q_valid,
    output logic        q_ready,
    input  logic [4:0]  q_addr,
    input  logic [31:0] q_data,
    input  logic [31:0] q_pc,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        hit_rs,
    output logic        hit_rt,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic [31:0] reg_pc,
    output logic        stall_req
);

    localparam int AW = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

    wr_entry_t     w_ent, q_ent, head, port;
    logic          fifo_empty, fifo_full;
    logic          push, pop;
    logic [AW-1:0] age_q, age_d;
    logic          stall_q, stall_d;

    assign w_ent = '{addr: w_addr, data: w_data, pc: w_pc};
    assign q_ent = '{addr: q_addr, data: q_data, pc: q_pc};

    assign q_ready = !fifo_full;
    // Writes to r0 are accepted on the handshake but never stored.
    assign push = reset && q_valid && q_ready && (q_addr != REG_ZERO);
    assign pop  = reset && !w_valid && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (push),
        .push_entry_i (q_ent),
        .pop_i        (pop),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .rs_i         (rs),
        .rt_i         (rt),
        .hit_rs_o     (hit_rs),
        .hit_rt_o     (hit_rt)
    );

    always_comb begin
        port = '0;
        if (w_valid)  port = w_ent;
        else if (pop) port = head;
    end

    assign reg_addr = port.addr;
    assign reg_data = port.data;
    assign reg_pc   = port.pc;

    // Age tracks how long the current head has been denied the port.
    always_comb begin
        age_d   = age_q;
        stall_d = stall_q;
        if (pop || fifo_empty)    age_d = '0;
        else if (age_q != AGE_LIM) age_d = age_q + 1'b1;
        if (pop)                  stall_d = 1'b0;
        else if (age_d == AGE_LIM) stall_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            age_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            age_q   <= age_d;
            stall_q <= stall_d;
        end
    end

    assign stall_req = stall_q;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter: directed vector table, two
// multi-cycle sequences, then random traffic against a queue-based model.
module tb_grf_write_arbiter;

    localparam int DEPTH   = 4;
    localparam int AGE_MAX = 8;
    localparam logic [31:0] PCX = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_valid;
    logic [4:0]  w_addr;
    logic [31:0] w_data, w_pc;
    logic        q_valid, q_ready;
    logic [4:0]  q_addr;
    logic [31:0] q_data, q_pc;
    logic [4:0]  rs, rt;
    logic        hit_rs, hit_rt;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data, reg_pc;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grf_write_arbiter #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
        .q_valid(q_valid), .q_ready(q_ready),
        .q_addr(q_addr), .q_data(q_data), .q_pc(q_pc),
        .rs(rs), .rt(rt), .hit_rs(hit_rs), .hit_rt(hit_rt),
        .reg_addr(reg_addr), .reg_data(reg_data), .reg_pc(reg_pc),
        .stall_req(stall_req)
    );

    typedef struct {
        logic        rst, wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        qv;
        logic [4:0]  qa;
        logic [31:0] qd;
        logic [4:0]  rs, rt;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy, ehrs, ehrt, estl;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic wv, logic [4:0] wa, logic [31:0] wd,
                                logic qv, logic [4:0] qa, logic [31:0] qd,
                                logic [4:0] prs, logic [4:0] prt,
                                logic [4:0] ea, logic [31:0] ed,
                                logic erdy, logic ehrs, logic ehrt, logic estl);
        vec_t v;
        v.rst = r; v.wv = wv; v.wa = wa; v.wd = wd;
        v.qv = qv; v.qa = qa; v.qd = qd; v.rs = prs; v.rt = prt;
        v.ea = ea; v.ed = ed; v.erdy = erdy; v.ehrs = ehrs; v.ehrt = ehrt; v.estl = estl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic qv, input logic [4:0] qa, input logic [31:0] qd,
                         input logic [4:0] prs, input logic [4:0] prt);
        reset = r; w_valid = wv; w_addr = wa; w_data = wd; w_pc = wd ^ PCX;
        q_valid = qv; q_addr = qa; q_data = qd; q_pc = qd ^ PCX; rs = prs; rt = prt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    ent_t mq[$];
    int   m_age;
    bit   m_stl;

    initial begin
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // rst wv wa wd qv qa qd rs rt | addr data rdy hrs hrt stall
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,     0, 0,  0, 0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 'h1234,   0, 0, 0,     0, 0,  5, 'h1234,   1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        1, 3, 'hAA,  3, 0,  0, 0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     3, 0,  3, 'hAA,     1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     3, 0,  0, 0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        1, 0, 'h55,  0, 0,  0, 0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     0, 0,  0, 0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 'h900,    1, 1, 'h11,  0, 0,  9, 'h900,    1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 'h900,    1, 2, 'h22,  1, 0,  9, 'h900,    1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 9, 'h900,    1, 3, 'h33,  2, 1,  9, 'h900,    1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 9, 'h900,    1, 4, 'h44,  3, 0,  9, 'h900,    1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 9, 'h900,    1, 7, 'h77,  4, 7,  9, 'h900,    0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     1, 0,  1, 'h11,     0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        1, 8, 'h88,  1, 0,  2, 'h22,     1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     0, 8,  3, 'h33,     1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     0, 0,  4, 'h44,     1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     0, 8,  8, 'h88,     1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,     0, 8,  0, 0,        1, 0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].qv, tbl[i].qa,
                  tbl[i].qd, tbl[i].rs, tbl[i].rt);
            @(negedge clk);
            chk($sformatf("vec%0d_addr", i),  32'(reg_addr), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_data", i),  reg_data, tbl[i].ed);
            chk($sformatf("vec%0d_pc", i),    reg_pc, (tbl[i].ea == 0) ? 32'h0 : (tbl[i].ed ^ PCX));
            chk($sformatf("vec%0d_ready", i), 32'(q_ready), 32'(tbl[i].erdy));
            chk($sformatf("vec%0d_hit_rs", i), 32'(hit_rs), 32'(tbl[i].ehrs));
            chk($sformatf("vec%0d_hit_rt", i), 32'(hit_rt), 32'(tbl[i].ehrt));
            chk($sformatf("vec%0d_stall", i), 32'(stall_req), 32'(tbl[i].estl));
            tick();
        end

        // Aging: one queued entry starved by the pipeline until a stall is requested.
        apply(1, 1, 10, 'hA0, 1, 6, 'h66, 0, 0);
        @(negedge clk);
        chk("age_c0_addr", 32'(reg_addr), 32'd10);
        tick();
        for (int i = 1; i <= 9; i++) begin
            apply(1, 1, 10, 'hA0 + i, 0, 0, 0, 6, 0);
            @(negedge clk);
            chk($sformatf("age_c%0d_stall", i), 32'(stall_req), 32'(i >= 9));
            chk($sformatf("age_c%0d_addr", i), 32'(reg_addr), 32'd10);
            chk($sformatf("age_c%0d_hit", i), 32'(hit_rs), 32'd1);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("age_grant_addr", 32'(reg_addr), 32'd6);
        chk("age_grant_data", reg_data, 32'h66);
        chk("age_grant_stall", 32'(stall_req), 32'd1);
        tick();
        @(negedge clk);
        chk("age_after_stall", 32'(stall_req), 32'd0);
        chk("age_after_addr", 32'(reg_addr), 32'd0);
        tick();

        // Reset with three entries queued: everything queued must vanish.
        apply(1, 1, 10, 'hB0, 1, 11, 'hB1, 0, 0); tick();
        apply(1, 1, 10, 'hB0, 1, 12, 'hB2, 0, 0); tick();
        apply(1, 1, 10, 'hB0, 1, 13, 'hB3, 0, 0); tick();
        apply(1, 1, 10, 'hB0, 0, 0, 0, 11, 12);
        @(negedge clk);
        chk("rst_pre_hit_rs", 32'(hit_rs), 32'd1);
        chk("rst_pre_hit_rt", 32'(hit_rt), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 11, 12);
        @(negedge clk);
        chk("rst_cycle_addr", 32'(reg_addr), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 11, 13);
            @(negedge clk);
            chk($sformatf("rst_post%0d_addr", i), 32'(reg_addr), 32'd0);
            chk($sformatf("rst_post%0d_hit_rs", i), 32'(hit_rs), 32'd0);
            chk($sformatf("rst_post%0d_hit_rt", i), 32'(hit_rt), 32'd0);
            chk($sformatf("rst_post%0d_stall", i), 32'(stall_req), 32'd0);
            chk($sformatf("rst_post%0d_ready", i), 32'(q_ready), 32'd1);
            tick();
        end

        // Random traffic against the model, starting from a clean reset.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        mq.delete(); m_age = 0; m_stl = 0;
        begin
            int mode = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic r, wv, qv, e_rdy, e_hrs, e_hrt, was_empty, mpop, mpush;
                logic [4:0] wa, qa;
                ent_t e_port;
                if (cyc % 40 == 0) mode = int'($urandom_range(0, 2));
                r  = ($urandom_range(0, 99) != 0);
                wv = (mode == 0) ? ($urandom_range(0, 1) == 1) :
                     (mode == 1) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
                wa = 5'($urandom_range(0, 31));
                qv = ($urandom_range(0, 1) == 1);
                qa = 5'($urandom_range(0, 7));
                apply(r, wv, wa, $urandom, qv, qa, $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                w_pc = $urandom;
                q_pc = $urandom;

                e_rdy = (mq.size() < DEPTH);
                e_hrs = 0; e_hrt = 0;
                foreach (mq[k]) begin
                    if (rs != 0 && mq[k].a == rs) e_hrs = 1;
                    if (rt != 0 && mq[k].a == rt) e_hrt = 1;
                end
                if (wv)                       e_port = '{a: w_addr, d: w_data, p: w_pc};
                else if (r && mq.size() > 0)  e_port = mq[0];
                else                          e_port = '0;

                @(negedge clk);
                chk("rnd_addr",  32'(reg_addr), 32'(e_port.a));
                chk("rnd_data",  reg_data, e_port.d);
                chk("rnd_pc",    reg_pc, e_port.p);
                chk("rnd_ready", 32'(q_ready), 32'(e_rdy));
                chk("rnd_hit_rs", 32'(hit_rs), 32'(e_hrs));
                chk("rnd_hit_rt", 32'(hit_rt), 32'(e_hrt));
                chk("rnd_stall", 32'(stall_req), 32'(m_stl));

                if (!r) begin
                    mq.delete(); m_age = 0; m_stl = 0;
                end else begin
                    was_empty = (mq.size() == 0);
                    mpop  = !wv && !was_empty;
                    mpush = qv && (mq.size() < DEPTH) && (qa != 0);
                    if (mpop)  void'(mq.pop_front());
                    if (mpush) mq.push_back('{a: q_addr, d: q_data, p: q_pc});
                    if (mpop || was_empty)  m_age = 0;
                    else if (m_age < AGE_MAX) m_age++;
                    if (mpop)                 m_stl = 0;
                    else if (m_age == AGE_MAX) m_stl = 1;
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
